// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles,
// declares lock on repeated equal periods and flags loss of the clock.
module clk_ratio_monitor #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int LOCK_CNT = 4
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             mismatch,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LC = 4'(LOCK_CNT);

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             same;
  logic             first;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_nxt;

  assign rise  = s2 & ~s3;
  assign same  = (cnt == period);
  assign first = (match_cnt == 4'd0);

  // match_cnt of zero marks the first measurement after arming
  always_comb begin
    match_nxt = 4'd1;
    if (!first && same)
      match_nxt = (match_cnt >= LC) ? LC : match_cnt + 4'd1;
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      hcnt         <= '0;
      match_cnt    <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      mismatch     <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      period_valid <= 1'b0;
      mismatch     <= 1'b0;

      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != TO)
        cnt <= cnt + CNT_W'(1);

      if (rise)
        hcnt <= {{(CNT_W-1){1'b0}}, s2};
      else if (s2 && hcnt != TO)
        hcnt <= hcnt + CNT_W'(1);

      // an edge always wins over a saturated counter
      if (rise) begin
        timeout <= 1'b0;
        unique case (state)
          IDLE: state <= MEASURE;
          default: begin
            period       <= cnt;
            high_time    <= hcnt;
            period_valid <= 1'b1;
            match_cnt    <= match_nxt;
            if (!first && !same) begin
              mismatch <= 1'b1;
              locked   <= 1'b0;
              state    <= MEASURE;
            end else if (match_nxt == LC) begin
              locked <= 1'b1;
              state  <= LOCKED;
            end
          end
        endcase
      end else if (cnt == TO) begin
        timeout   <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: the driver queues one expected
// record per measured period, a negedge monitor checks each period_valid.
module tb_clk_ratio_monitor;

  localparam int TO = 20;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
    logic        mm;
    logic        lk;
  } exp_t;

  logic        clki = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        period_valid;
  logic        mismatch;
  logic        locked;
  logic        timeout;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_pv = 0;
  bit   watch_to = 0;

  bit   armed = 0;
  bit   m_lock = 0;
  int   m_match = 0;
  int   prev_n = 0;
  int   prev_h = 0;
  int   last_p = 0;

  clk_ratio_monitor #(
    .CNT_W(16),
    .TIMEOUT(TO),
    .LOCK_CNT(4)
  ) dut (
    .clki(clki),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .mismatch(mismatch),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clki = ~clki;

  always @(posedge clki) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    armed   = 0;
    m_match = 0;
    m_lock  = 0;
  endtask

  // Edge-level model: each rising edge closes the previous period.
  task automatic edge_model(input int n, input int h);
    bit mm;
    if (!armed) begin
      armed = 1;
    end else begin
      mm = 0;
      if (m_match == 0)
        m_match = 1;
      else if (prev_n == last_p)
        m_match = (m_match >= 4) ? 4 : m_match + 1;
      else begin
        m_match = 1;
        mm = 1;
      end
      if (mm)
        m_lock = 0;
      else if (m_match == 4)
        m_lock = 1;
      q.push_back('{p: 16'(prev_n), h: 16'(prev_h), mm: mm, lk: m_lock});
      last_p = prev_n;
    end
    prev_n = n;
    prev_h = h;
  endtask

  task automatic run(input int n, input int h, input int k);
    for (int i = 0; i < k; i++) begin
      edge_model(n, h);
      sig_in = 1'b1;
      repeat (h) @(negedge clki);
      sig_in = 1'b0;
      repeat (n - h) @(negedge clki);
    end
  endtask

  task automatic gap();
    sig_in = 1'b0;
    repeat (TO + 8) @(negedge clki);
    model_clear();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_period"}, int'(period), 0);
    chk({nm, "_high"}, int'(high_time), 0);
    chk({nm, "_flags"},
        int'({period_valid, mismatch, locked, timeout}), 0);
  endtask

  always @(negedge clki) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (period_valid) begin
        last_pv = cyc;
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: got p=%0d h=%0d expected none",
                   period, high_time);
        end else begin
          e = q.pop_front();
          if (period !== e.p || high_time !== e.h ||
              mismatch !== e.mm || locked !== e.lk) begin
            n_err++;
            $display("FAIL meas: got p=%0d h=%0d mm=%0b lk=%0b expected p=%0d h=%0d mm=%0b lk=%0b",
                     period, high_time, mismatch, locked,
                     e.p, e.h, e.mm, e.lk);
          end
        end
      end else if (mismatch) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_mismatch: got 1 expected 0");
      end
      if (watch_to && timeout) begin
        n_vec++;
        n_err++;
        watch_to = 0;
        $display("FAIL timeout_at_limit: got 1 expected 0");
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clki);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clki);

    run(2, 1, 11);
    gap();

    run(8, 4, 5);
    run(6, 3, 6);
    gap();

    run(4, 2, 6);
    for (int i = 0; i < 200 && !timeout; i++) @(negedge clki);
    chk("to_asserted", int'(timeout), 1);
    chk("to_delay", cyc - last_pv, TO);
    chk("to_unlock", int'(locked), 0);
    chk("to_period_hold", int'(period), 4);
    model_clear();
    run(4, 2, 6);
    chk("to_cleared", int'(timeout), 0);
    chk("relock", int'(locked), 1);
    gap();

    run(4, 2, 6);
    repeat (5) @(negedge clki);
    chk("pre_rst_lock", int'(locked), 1);
    chk("pre_rst_drained", q.size(), 0);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (3) @(negedge clki);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    model_clear();

    run(10, 3, 4);
    gap();

    run(20, 10, 1);
    watch_to = 1;
    run(20, 10, 4);
    watch_to = 0;
    gap();

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
